// File: rtl/seg_scan_ctrl_if.sv
// Host/display bundle for seg_scan_ctrl: register-file writes and scan enable in,
// decoder select, segment data and frame pulse out.
interface seg_scan_ctrl_if;
    logic       scan_en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [2:0] sel;
    logic       sel_en;
    logic [7:0] seg;
    logic       frame_tick;

    modport master (
        output scan_en, wr_en, wr_addr, wr_data,
        input  sel, sel_en, seg, frame_tick
    );

    modport slave (
        input  scan_en, wr_en, wr_addr, wr_data,
        output sel, sel_en, seg, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode seven-segment scan controller.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
    parameter int unsigned DIV_CNT   = 50000,
    parameter int unsigned BLANK_CNT = 500,
    parameter int unsigned DIGITS    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus
);

    localparam int unsigned CMAX = (DIV_CNT > BLANK_CNT) ? DIV_CNT : BLANK_CNT;
    localparam int unsigned CW   = $clog2((CMAX > 2) ? CMAX : 2);

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV_CNT - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CNT == 0) ? 0 : BLANK_CNT - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d, idx_next;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start;

    logic [4:0]    digit_q [8];
    logic [7:0]    lz_blank;

    logic [2:0]    sel_q, sel_d;
    logic          sel_en_q, sel_en_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_tick_q, frame_tick_d;

    function automatic logic [7:0] encode(input logic [4:0] d);
        logic [6:0] s;
        case (d[3:0])
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return {~d[4], s};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                digit_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            digit_q[bus.wr_addr] <= bus.wr_data;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // A digit blanks only while it and every higher active digit are all-zero (dp included).
    always_comb begin
        logic        run;
        int unsigned i;
        lz_blank = '0;
        run      = 1'b1;
        for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
            i           = DIGITS - 1 - k;
            run         = run & (digit_q[3'(i)] == 5'h00);
            lz_blank[3'(i)] = run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        if (!bus.scan_en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
                SHOW: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_d = '0;
                        if (BLANK_CNT != 0) begin
                            state_d = BLANK;
                        end else begin
                            idx_d = idx_next;
                            start = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        idx_d   = idx_next;
                        cnt_d   = '0;
                        start   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so sel/sel_en/seg move together on one edge.
    always_comb begin
        sel_d        = idx_d;
        sel_en_d     = (state_d == SHOW);
        seg_d        = 8'hFF;
        frame_tick_d = start && (idx_d == 3'd0);
        if (sel_en_d && !lz_blank[idx_d]) begin
            seg_d = encode(digit_q[idx_d]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            sel_q        <= '0;
            sel_en_q     <= 1'b0;
            seg_q        <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            sel_en_q     <= sel_en_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.sel_en     = sel_en_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: two instances (8 digits with blank gap,
// 3 digits without) checked cycle by cycle against a spec-derived scan model.
module tb_seg_scan_ctrl;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic [7:0] seg;
        logic       ft;
    } obs_t;

    localparam obs_t DARK = '{sel: 3'd0, en: 1'b0, seg: 8'hFF, ft: 1'b0};
    localparam logic [7:0] ENC [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic clk;
    logic rst_n;

    seg_scan_ctrl_if bus_a ();
    seg_scan_ctrl_if bus_b ();

    seg_scan_ctrl #(.DIV_CNT(4), .BLANK_CNT(2), .DIGITS(8)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    seg_scan_ctrl #(.DIV_CNT(4), .BLANK_CNT(0), .DIGITS(3)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    obs_t oa, ob, e;
    assign oa = {bus_a.sel, bus_a.sel_en, bus_a.seg, bus_a.frame_tick};
    assign ob = {bus_b.sel, bus_b.sel_en, bus_b.seg, bus_b.frame_tick};

    obs_t qa [$];
    obs_t qb [$];
    logic [7:0] exp_seg_a [8];
    logic [7:0] exp_seg_b [3];
    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: got time limit reached, want $finish");
        $fatal(1, "watchdog");
    end

    // Expected outputs for scan cycles start..start+n-1, cycle 1 being the first edge after enable.
    task automatic push_scan_a(input int start, input int n);
        for (int c = start; c < start + n; c++) begin
            int   pos;
            int   d;
            obs_t x;
            pos = (c - 1) % 48;
            d   = pos / 6;
            if (pos % 6 < 4) x = {3'(d), 1'b1, exp_seg_a[d], (pos == 0)};
            else             x = {3'(d), 1'b0, 8'hFF, 1'b0};
            qa.push_back(x);
        end
    endtask

    task automatic push_scan_b(input int start, input int n);
        for (int c = start; c < start + n; c++) begin
            int   pos;
            int   d;
            obs_t x;
            pos = (c - 1) % 12;
            d   = pos / 4;
            x   = {3'(d), 1'b1, exp_seg_b[d], (pos == 0)};
            qb.push_back(x);
        end
    endtask

    task automatic write_a(input logic [2:0] a, input logic [4:0] d);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = a; bus_a.wr_data = d;
        @(negedge clk);
        bus_a.wr_en = 1'b0;
    endtask

    task automatic write_b(input logic [2:0] a, input logic [4:0] d);
        bus_b.wr_en = 1'b1; bus_b.wr_addr = a; bus_b.wr_data = d;
        @(negedge clk);
        bus_b.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.scan_en = 1'b0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_b.scan_en = 1'b0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin qa.push_back(DARK); qb.push_back(DARK); end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            e = qa.pop_front(); n_checks++;
            if (oa !== e) begin
                n_fail++;
                $display("FAIL reset_a cyc %0d: got sel=%0d en=%b seg=%h ft=%b want sel=%0d en=%b seg=%h ft=%b",
                         c, oa.sel, oa.en, oa.seg, oa.ft, e.sel, e.en, e.seg, e.ft);
            end
            e = qb.pop_front(); n_checks++;
            if (ob !== e) begin
                n_fail++;
                $display("FAIL reset_b cyc %0d: got sel=%0d en=%b seg=%h ft=%b want sel=%0d en=%b seg=%h ft=%b",
                         c, ob.sel, ob.en, ob.seg, ob.ft, e.sel, e.en, e.seg, e.ft);
            end
        end
    endtask

    task automatic test_scan_frame();
        for (int i = 0; i < 8; i++) begin
            write_a(3'(i), 5'(i));
            exp_seg_a[i] = ENC[i];
        end
        write_b(3'd0, 5'h0A);
        write_b(3'd1, 5'h1B);
        write_b(3'd2, 5'h0C);
        exp_seg_b[0] = 8'h88; exp_seg_b[1] = 8'h03; exp_seg_b[2] = 8'hC6;
        bus_a.scan_en = 1'b1; bus_b.scan_en = 1'b1;
        push_scan_a(1, 49); qa.push_back(DARK);
        push_scan_b(1, 49); qb.push_back(DARK);
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            e = qa.pop_front(); n_checks++;
            if (oa !== e) begin
                n_fail++;
                $display("FAIL frame_a cyc %0d: got sel=%0d en=%b seg=%h ft=%b want sel=%0d en=%b seg=%h ft=%b",
                         c, oa.sel, oa.en, oa.seg, oa.ft, e.sel, e.en, e.seg, e.ft);
            end
            e = qb.pop_front(); n_checks++;
            if (ob !== e) begin
                n_fail++;
                $display("FAIL frame_b cyc %0d: got sel=%0d en=%b seg=%h ft=%b want sel=%0d en=%b seg=%h ft=%b",
                         c, ob.sel, ob.en, ob.seg, ob.ft, e.sel, e.en, e.seg, e.ft);
            end
            if (c == 49) begin bus_a.scan_en = 1'b0; bus_b.scan_en = 1'b0; end
        end
    endtask

    task automatic test_write_live();
        bus_a.scan_en = 1'b1;
        push_scan_a(1, 14);
        exp_seg_a[2] = 8'h08;
        push_scan_a(15, 6);
        qa.push_back(DARK);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            e = qa.pop_front(); n_checks++;
            if (oa !== e) begin
                n_fail++;
                $display("FAIL write_live cyc %0d: got sel=%0d en=%b seg=%h ft=%b want sel=%0d en=%b seg=%h ft=%b",
                         c, oa.sel, oa.en, oa.seg, oa.ft, e.sel, e.en, e.seg, e.ft);
            end
            if (c == 13) begin bus_a.wr_en = 1'b1; bus_a.wr_addr = 3'd2; bus_a.wr_data = 5'h1A; end
            if (c == 14) bus_a.wr_en = 1'b0;
            if (c == 20) bus_a.scan_en = 1'b0;
        end
    endtask

    task automatic test_abort();
        bus_a.scan_en = 1'b1;
        push_scan_a(1, 32);
        qa.push_back(DARK); qa.push_back(DARK);
        push_scan_a(1, 4);
        qa.push_back(DARK);
        for (int c = 1; c <= 39; c++) begin
            @(negedge clk);
            e = qa.pop_front(); n_checks++;
            if (oa !== e) begin
                n_fail++;
                $display("FAIL abort cyc %0d: got sel=%0d en=%b seg=%h ft=%b want sel=%0d en=%b seg=%h ft=%b",
                         c, oa.sel, oa.en, oa.seg, oa.ft, e.sel, e.en, e.seg, e.ft);
            end
            if (c == 32) bus_a.scan_en = 1'b0;
            if (c == 34) bus_a.scan_en = 1'b1;
            if (c == 38) bus_a.scan_en = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        bus_a.scan_en = 1'b1;
        push_scan_a(1, 23);
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            e = qa.pop_front(); n_checks++;
            if (oa !== e) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d: got sel=%0d en=%b seg=%h ft=%b want sel=%0d en=%b seg=%h ft=%b",
                         c, oa.sel, oa.en, oa.seg, oa.ft, e.sel, e.en, e.seg, e.ft);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (oa !== DARK) begin
            n_fail++;
            $display("FAIL async_reset: got sel=%0d en=%b seg=%h ft=%b want sel=0 en=0 seg=ff ft=0",
                     oa.sel, oa.en, oa.seg, oa.ft);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
`ifdef SEG_SCAN_LZB_EN
            exp_seg_a[i] = (i == 0) ? 8'hC0 : 8'hFF;
`else
            exp_seg_a[i] = 8'hC0;
`endif
        end
        push_scan_a(1, 12);
        qa.push_back(DARK);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            e = qa.pop_front(); n_checks++;
            if (oa !== e) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: got sel=%0d en=%b seg=%h ft=%b want sel=%0d en=%b seg=%h ft=%b",
                         c, oa.sel, oa.en, oa.seg, oa.ft, e.sel, e.en, e.seg, e.ft);
            end
            if (c == 12) bus_a.scan_en = 1'b0;
        end
    endtask

    task automatic test_lzb();
        write_a(3'd0, 5'h07);
        write_a(3'd2, 5'h03);
        write_b(3'd0, 5'h05);
        write_b(3'd5, 5'h08);
`ifdef SEG_SCAN_LZB_EN
        exp_seg_a = '{8'hF8, 8'hC0, 8'hB0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_seg_b = '{8'h92, 8'hFF, 8'hFF};
`else
        exp_seg_a = '{8'hF8, 8'hC0, 8'hB0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        exp_seg_b = '{8'h92, 8'hC0, 8'hC0};
`endif
        bus_a.scan_en = 1'b1; bus_b.scan_en = 1'b1;
        push_scan_a(1, 48); qa.push_back(DARK);
        push_scan_b(1, 48); qb.push_back(DARK);
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk);
            e = qa.pop_front(); n_checks++;
            if (oa !== e) begin
                n_fail++;
                $display("FAIL lzb_a cyc %0d: got sel=%0d en=%b seg=%h ft=%b want sel=%0d en=%b seg=%h ft=%b",
                         c, oa.sel, oa.en, oa.seg, oa.ft, e.sel, e.en, e.seg, e.ft);
            end
            e = qb.pop_front(); n_checks++;
            if (ob !== e) begin
                n_fail++;
                $display("FAIL lzb_b cyc %0d: got sel=%0d en=%b seg=%h ft=%b want sel=%0d en=%b seg=%h ft=%b",
                         c, ob.sel, ob.en, ob.seg, ob.ft, e.sel, e.en, e.seg, e.ft);
            end
            if (c == 48) begin bus_a.scan_en = 1'b0; bus_b.scan_en = 1'b0; end
        end
    endtask

    initial begin
        test_reset();
        test_scan_frame();
        test_write_live();
        test_abort();
        test_async_reset();
        test_lzb();
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
